// File: rtl/instruction_prefetcher.sv
// Wishbone master that streams sequential instruction words from boot flash into
// a small FIFO for the fetch stage, handling redirects, retries and bus errors.
`timescale 1ns/1ps
module instruction_prefetcher #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        cyc_o,
  output logic        stb_o,
  output logic [31:0] adr_o,
  output logic [3:0]  sel_o,
  output logic        we_o,
  output logic [31:0] dat_o,
  input  logic [31:0] dat_i,
  input  logic        ack_i,
  input  logic        err_i,
  input  logic        rty_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        instr_valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] instr_pc_o,
  output logic        instr_err_o,
  input  logic        instr_ready_i
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {ST_FETCH, ST_IDLE, ST_DRAIN, ST_HALT} state_t;

  state_t           state;
  logic [31:0]      fetch_pc;
  logic [31:0]      fifo_data [DEPTH];
  logic [31:0]      fifo_pc   [DEPTH];
  logic [DEPTH-1:0] fifo_err;
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [CW-1:0]    count;
  logic [CW-1:0]    count_next;
  logic             term;
  logic             push;
  logic             pop;
  logic             credit;
  logic [31:0]      redir_pc;
  logic [31:0]      next_pc;
  logic             unused_pc_bits;

  assign sel_o          = 4'hF;
  assign we_o           = 1'b0;
  assign dat_o          = 32'h0;
  assign redir_pc       = {redirect_pc_i[31:2], 2'b00};
  assign unused_pc_bits = ^redirect_pc_i[1:0];
  assign next_pc        = fetch_pc + 32'd4;

  assign instr_valid_o  = (count != '0);
  assign instr_o        = fifo_data[rd_ptr];
  assign instr_pc_o     = fifo_pc[rd_ptr];
  assign instr_err_o    = fifo_err[rd_ptr];

  // Credit looks at post-edge occupancy so a pop this cycle frees a slot immediately.
  always_comb begin
    term       = cyc_o & (ack_i | err_i | rty_i);
    push       = (state == ST_FETCH) & term & ~redirect_i & (err_i | ~rty_i);
    pop        = instr_valid_o & instr_ready_i & ~redirect_i;
    count_next = count;
    if (redirect_i) begin
      count_next = '0;
    end else begin
      count_next = count + CW'(push) - CW'(pop);
    end
    credit = (count_next < DEPTH_C);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= ST_IDLE;
      cyc_o    <= 1'b0;
      stb_o    <= 1'b0;
      adr_o    <= 32'h0;
      fetch_pc <= RESET_PC;
    end else begin
      case (state)
        ST_FETCH: begin
          if (term && redirect_i) begin
            adr_o    <= redir_pc;
            fetch_pc <= redir_pc;
          end else if (term && err_i) begin
            state <= ST_HALT;
            cyc_o <= 1'b0;
            stb_o <= 1'b0;
          end else if (term && rty_i) begin
            state <= ST_IDLE;
            cyc_o <= 1'b0;
            stb_o <= 1'b0;
          end else if (term) begin
            fetch_pc <= next_pc;
            adr_o    <= next_pc;
            if (!credit) begin
              state <= ST_IDLE;
              cyc_o <= 1'b0;
              stb_o <= 1'b0;
            end
          end else if (redirect_i) begin
            // The bus keeps the stale request until the slave terminates it.
            state    <= ST_DRAIN;
            fetch_pc <= redir_pc;
          end
        end
        ST_DRAIN: begin
          if (term) begin
            state    <= ST_FETCH;
            adr_o    <= redirect_i ? redir_pc : fetch_pc;
            fetch_pc <= redirect_i ? redir_pc : fetch_pc;
          end else if (redirect_i) begin
            fetch_pc <= redir_pc;
          end
        end
        ST_IDLE: begin
          if (redirect_i) begin
            state    <= ST_FETCH;
            cyc_o    <= 1'b1;
            stb_o    <= 1'b1;
            adr_o    <= redir_pc;
            fetch_pc <= redir_pc;
          end else if (credit) begin
            state <= ST_FETCH;
            cyc_o <= 1'b1;
            stb_o <= 1'b1;
            adr_o <= fetch_pc;
          end
        end
        ST_HALT: begin
          if (redirect_i) begin
            state    <= ST_FETCH;
            cyc_o    <= 1'b1;
            stb_o    <= 1'b1;
            adr_o    <= redir_pc;
            fetch_pc <= redir_pc;
          end
        end
        default: begin
          state <= ST_IDLE;
          cyc_o <= 1'b0;
          stb_o <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      fifo_err <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        fifo_data[i] <= 32'h0;
        fifo_pc[i]   <= 32'h0;
      end
    end else if (redirect_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        fifo_data[wr_ptr] <= err_i ? 32'h0 : dat_i;
        fifo_pc[wr_ptr]   <= fetch_pc;
        fifo_err[wr_ptr]  <= err_i;
        wr_ptr            <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count <= count_next;
    end
  end

endmodule
